// File: rtl/quo_bcd_pkg.sv
// quo_bcd_pkg: shared types and constants for the quotient-to-BCD converter.
// Holds the converter state encoding, the BCD digit width and the helper that
// sizes the iteration counter from the binary input width.
package quo_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // Counter must hold the value BWI itself, hence clog2(BWI+1).
  function automatic int cnt_width(input int bwi);
    return $clog2(bwi + 1);
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3: single-digit add-3 correction used by the double-dabble loop.
// A digit of 5 or more gets 3 added so that the following left shift
// carries correctly into the next decimal digit. No carry leaves the digit.
module bcd_adj3
  import quo_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  // Conditional +3 on a digit that would exceed 9 after doubling
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_W'(5)) begin
      digit_out = digit_in + BCD_W'(3);
    end
  end

endmodule

// File: rtl/quo_bcd_conv.sv
// quo_bcd_conv: sequential binary-to-BCD converter behind the unsigned divider.
// Accepts one quotient word on a valid/ready handshake, converts it one bit
// per clock with shift-and-add-3, and holds the packed BCD result until the
// consumer takes it.
// Optional feature macro: QUO_BCD_CONV_OVF_EN adds the o_ovf port and
// saturates the result to all nines when the value does not fit in NDIG digits.
// Without it, the result is the value modulo 10^NDIG.
module quo_bcd_conv
  import quo_bcd_pkg::*;
#(
  parameter int BWI  = 8,
  parameter int NDIG = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [BWI-1:0]        i1,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [BCD_W*NDIG-1:0] o1,
`ifdef QUO_BCD_CONV_OVF_EN
  output logic                  busy,
  output logic                  o_ovf
`else
  output logic                  busy
`endif
);

  localparam int CW = cnt_width(BWI);
  localparam int DW = BCD_W * NDIG;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   bcd_r;
  logic [DW-1:0]   bcd_adj;
  logic [DW-1:0]   bcd_shift;
  logic [BWI-1:0]  bin_r;
  logic [BWI-1:0]  bin_shift;
  logic [CW-1:0]   cnt;
  logic            carry_out;

`ifdef QUO_BCD_CONV_OVF_EN
  logic            ovf_r;
`else
  logic            carry_unused;
  assign carry_unused = carry_out;
`endif

  // One add-3 corrector per BCD digit, applied before every shift
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .digit_in  (bcd_r[g*BCD_W +: BCD_W]),
      .digit_out (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  // Shift the corrected digits and the remaining binary bits left by one
  always_comb begin
    carry_out = 1'b0;
    bcd_shift = '0;
    bin_shift = '0;
    {carry_out, bcd_shift, bin_shift} = {bcd_adj, bin_r, 1'b0};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the last iteration is the one that sees cnt == 1
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)         state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1))   state_nxt = DONE;
      DONE:    if (o_ready)         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one double-dabble iteration per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
`ifdef QUO_BCD_CONV_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      if (state == IDLE && i_valid) begin
        bcd_r <= '0;
        bin_r <= i1;
        cnt   <= CW'(BWI);
`ifdef QUO_BCD_CONV_OVF_EN
        ovf_r <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        bcd_r <= bcd_shift;
        bin_r <= bin_shift;
        cnt   <= cnt - CW'(1);
`ifdef QUO_BCD_CONV_OVF_EN
        ovf_r <= ovf_r | carry_out;
`endif
      end
    end
  end

  // Handshake flags are pure state decodes
  always_comb begin
    i_ready = (state == IDLE);
    o_valid = (state == DONE);
    busy    = (state == SHIFT);
  end

  // Result drive; an overflowed result saturates to all nines once done
`ifdef QUO_BCD_CONV_OVF_EN
  always_comb begin
    o1    = bcd_r;
    o_ovf = ovf_r;
    if (state == DONE && ovf_r) begin
      o1 = {NDIG{4'h9}};
    end
  end
`else
  always_comb begin
    o1 = bcd_r;
  end
`endif

endmodule

// File: tb/tb_quo_bcd_conv.sv
// tb_quo_bcd_conv: self-checking bench for quo_bcd_conv.
// Expected BCD values come from a decimal reference model, are queued when a
// word is accepted and popped when the converter presents its result.
module tb_quo_bcd_conv;

  localparam int BWI   = 8;
  localparam int NDIG  = 3;
  localparam int NDIG2 = 2;
`ifdef QUO_BCD_CONV_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_ready, o_valid, busy;
  logic [7:0]  i1;
  logic [11:0] o1;
  logic        i_valid2, o_ready2, i_ready2, o_valid2, busy2;
  logic [7:0]  i1_2;
  logic [7:0]  o1_2;
`ifdef QUO_BCD_CONV_OVF_EN
  logic        o_ovf, o_ovf2;
`endif

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  quo_bcd_conv #(.BWI(BWI), .NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i1(i1),
    .o_valid(o_valid), .o_ready(o_ready), .o1(o1),
`ifdef QUO_BCD_CONV_OVF_EN
    .busy(busy), .o_ovf(o_ovf)
`else
    .busy(busy)
`endif
  );

  quo_bcd_conv #(.BWI(BWI), .NDIG(NDIG2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid2), .i_ready(i_ready2), .i1(i1_2),
    .o_valid(o_valid2), .o_ready(o_ready2), .o1(o1_2),
`ifdef QUO_BCD_CONV_OVF_EN
    .busy(busy2), .o_ovf(o_ovf2)
`else
    .busy(busy2)
`endif
  );

  // Decimal reference: lowest nd decimal digits of v, packed BCD
  function automatic logic [11:0] ref_bcd(input int v, input int nd);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Offer a word to dut and push its expected result when accepted
  task automatic send(input logic [7:0] v, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    i_valid = 1'b1;
    i1 = v;
    while (!i_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (i_ready) begin
      ok = 1'b1;
      @(posedge clk);
      exp_q.push_back(ref_bcd(int'(v), NDIG));
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  // Wait (bounded) for dut o_valid, reporting the number of cycles waited
  task automatic wait_valid(output bit ok, output int n);
    n = 0;
    while (!o_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = o_valid;
  endtask

  task automatic handshake();
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0; o_ready = 1'b0; i1 = '0;
    i_valid2 = 1'b0; o_ready2 = 1'b0; i1_2 = '0;
    @(negedge clk);
    total++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0 || o1 !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got rdy=%b vld=%b busy=%b o1=%h want 1 0 0 000", i_ready, o_valid, busy, o1);
    end
`ifdef QUO_BCD_CONV_OVF_EN
    total++;
    if (o_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ovf: got %b want 0", o_ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got rdy=%b vld=%b busy=%b want 1 0 0", i_ready, o_valid, busy);
    end
  endtask

  task automatic test_convert();
    logic [7:0]  vals [4] = '{8'd0, 8'd255, 8'd99, 8'd128};
    logic [11:0] e;
    bit ok;
    int n;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], ok);
      total++;
      if (!ok) begin
        bad++;
        $display("[TB] FAIL convert_accept: got no accept want accept of %0d", vals[i]);
        continue;
      end
      wait_valid(ok, n);
      total++;
      if (!ok || n != BWI) begin
        bad++;
        $display("[TB] FAIL convert_latency: got valid=%b after %0d cycles want 1 after %0d", ok, n, BWI);
      end
      if (ok && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (o1 !== e) begin
          bad++;
          $display("[TB] FAIL convert_value: in=%0d got %h want %h", vals[i], o1, e);
        end
`ifdef QUO_BCD_CONV_OVF_EN
        total++;
        if (o_ovf !== 1'b0) begin
          bad++;
          $display("[TB] FAIL convert_ovf: got %b want 0", o_ovf);
        end
`endif
      end
      handshake();
      total++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL convert_release: got rdy=%b vld=%b want 1 0", i_ready, o_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [11:0] e;
    bit ok;
    int n;
    send(8'd42, ok);
    wait_valid(ok, n);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL bp_valid: got valid=%b want 1", ok);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    i_valid = 1'b1;
    i1 = 8'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (o1 !== e || o_valid !== 1'b1 || i_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold: cyc=%0d got o1=%h vld=%b rdy=%b want %h 1 0", c, o1, o_valid, i_ready, e);
      end
    end
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    total++;
    if (i_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_reopen: got rdy=%b busy=%b want 1 0", i_ready, busy);
    end
    @(posedge clk);
    exp_q.push_back(ref_bcd(7, NDIG));
    @(negedge clk);
    i_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_accept: got busy=%b want 1", busy);
    end
    wait_valid(ok, n);
    total++;
    if (!ok || o1 !== exp_q[0]) begin
      bad++;
      $display("[TB] FAIL bp_next: got valid=%b o1=%h want 1 %h", ok, o1, exp_q[0]);
    end
    void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    bit ok, seen;
    int n;
    send(8'd200, ok);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0 || o1 !== 12'h000) begin
      bad++;
      $display("[TB] FAIL abort_reset: got rdy=%b vld=%b busy=%b o1=%h want 1 0 0 000", i_ready, o_valid, busy, o1);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= o_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_novalid: got o_valid seen=%b want 0", seen);
    end
    send(8'd37, ok);
    wait_valid(ok, n);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL abort_next_valid: got valid=%b want 1", ok);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (o1 !== e || e !== 12'h037) begin
        bad++;
        $display("[TB] FAIL abort_next_value: got %h want 037", o1);
      end
    end
    handshake();
  endtask

  task automatic test_ndig2();
    logic [7:0] vals [2] = '{8'd200, 8'd99};
    logic [7:0] exp2_q[$];
    logic       ovf_q[$];
    logic [11:0] r;
    logic [7:0] e;
    logic       eo;
    int n;
    for (int i = 0; i < 2; i++) begin
      i_valid2 = 1'b1;
      i1_2 = vals[i];
      n = 0;
      while (!i_ready2 && n < 64) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      r = ref_bcd(int'(vals[i]), NDIG2);
      eo = (vals[i] > 8'd99);
      exp2_q.push_back((eo && OVF_EN) ? 8'h99 : r[7:0]);
      ovf_q.push_back(eo);
      @(negedge clk);
      i_valid2 = 1'b0;
      n = 0;
      while (!o_valid2 && n < 64) begin
        @(negedge clk);
        n++;
      end
      e = exp2_q.pop_front();
      eo = ovf_q.pop_front();
      total++;
      if (o_valid2 !== 1'b1 || o1_2 !== e) begin
        bad++;
        $display("[TB] FAIL ndig2_value: in=%0d got vld=%b o1=%h want 1 %h", vals[i], o_valid2, o1_2, e);
      end
`ifdef QUO_BCD_CONV_OVF_EN
      total++;
      if (o_ovf2 !== eo) begin
        bad++;
        $display("[TB] FAIL ndig2_ovf: in=%0d got %b want %b", vals[i], o_ovf2, eo);
      end
`endif
      o_ready2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      o_ready2 = 1'b0;
    end
  endtask

  task automatic test_sweep();
    logic [11:0] e;
    bit ok;
    int n;
    for (int v = 0; v < 256; v++) begin
      send(8'(v), ok);
      wait_valid(ok, n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sweep_valid: in=%0d got valid=%b want 1", v, ok);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (o1 !== e) begin
          bad++;
          $display("[TB] FAIL sweep_value: in=%0d got %h want %h", v, o1, e);
        end
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_pressure();
    test_reset_mid();
    test_ndig2();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
